rcv_frame_checker: RTL and testbench
====================================

Name: rcv_frame_checker

Overview:
- Parametrised receive-side frame checker for the UART; successor to the single-bit receive parity checker.
- Sits between the receiver's bit-timing logic (one BitValid strobe per sampled bit) and the receive data register.
- Assembles data bits LSB first, checks parity (none/even/odd, selected at run time) and checks 1 or 2 stop bits.
- Presents the data word with sticky parity and framing error flags.

Parameters:
- DATA_BITS, 8, data bits per frame, legal 5..9.
- STOP_BITS, 1, stop bits checked per frame, legal 1 or 2.
- ERR_CNT_W, 8, width of error counter (used only with optional feature).

Ports:
- Clock  input  1  system clock, all state on rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- FrameStart  input  1  one-cycle pulse: start bit validated, next BitValid is data bit 0.
- BitValid  input  1  one-cycle strobe: RxD holds a sampled bit this cycle.
- RxD  input  1  sampled serial bit.
- ParityMode  input  2  00 none, 01 even, 10 odd, 11 treated as none.
- ClearErr  input  1  clears sticky error flags (and counter).
- RxData  output  DATA_BITS  last completed frame's data, bit 0 = first received.
- DataValid  output  1  one-cycle pulse, frame complete.
- RxParityErr  output  1  sticky parity error.
- RxFrameErr  output  1  sticky stop-bit error.
- Busy  output  1  high when state != IDLE.
- ErrCount  output  ERR_CNT_W  errored-frame count (see Optional Feature).

Behaviour:
- Reset (async, Reset_n low): state IDLE, RxData 0, DataValid 0, RxParityErr 0, RxFrameErr 0, Busy 0, ErrCount 0, shift reg/counters/running parity 0. Reset mid-frame discards the frame with no DataValid.
- FSM states: IDLE, DATA, PAR, STOP.
- IDLE -> DATA on FrameStart: clear bit counter and running parity, latch ParityMode (changes mid-frame ignored).
- DATA, on BitValid: shift RxD into shift reg MSB, shift right (LSB-first assembly); parity ^= RxD; count++. After DATA_BITS strobes go to PAR if latched mode is even/odd, else STOP.
- PAR, on BitValid: expected = running parity (even) or ~running parity (odd). Record per-frame parity fail if RxD != expected. Go to STOP.
- STOP, on BitValid: RxD = 0 records per-frame framing fail. After STOP_BITS strobes go to IDLE and complete the frame.
- Completion: on the edge sampling the final stop-bit strobe (cycle N), register RxData, pulse DataValid high in cycle N+1 for exactly one cycle, and set the sticky flags from the per-frame fails in the same edge.
- RxData holds its value until the next completion.
- Cycles without BitValid leave all state unchanged.
- FrameStart while not IDLE: abort current frame, restart at DATA bit 0. No DataValid and no flag update for the aborted frame.
- FrameStart and BitValid in the same cycle: FrameStart wins; BitValid ignored.
- ClearErr: clears RxParityErr/RxFrameErr next edge. If a frame completes with an error in the same cycle, set wins.
- Busy is combinational from state.

Optional Feature:
- Macro RCV_ERR_COUNT_EN.
- Defined: ErrCount increments by 1 per completed frame with parity or framing fail (one count even if both). Saturates at all-ones. ClearErr zeroes it; clear plus increment in the same cycle gives 1.
- Undefined: no counter logic; ErrCount port is present and tied to 0.

Test Plan:
- Reset low mid-DATA, release -> all outputs 0, Busy 0; next clean frame 0xA5 even parity completes normally.
- DATA_BITS=8, even, STOP_BITS=1; send 0xA5 (bits 1,0,1,0,0,1,0,1), parity 0, stop 1 -> RxData=0xA5, DataValid one cycle after stop strobe, both flags 0.
- Odd mode, 0x03 with parity bit 0 -> DataValid, RxParityErr=1, RxFrameErr=0. Then ClearErr -> RxParityErr=0. With macro: ErrCount 1 -> 0.
- STOP_BITS=2, parity none, 0x7E with second stop bit 0 -> RxFrameErr=1, RxData=0x7E. Idle cycles between strobes change nothing.
- FrameStart after 4 data bits, then full frame 0x3C -> single DataValid with 0x3C, no errors. ParityMode toggled mid-frame has no effect.
- Macro on, ERR_CNT_W=2: 4 errored frames -> ErrCount 1,2,3,3 (saturates). ClearErr coincident with errored completion -> flag stays 1, ErrCount=1.

Source files
------------

// File: rtl/rcv_frame_checker.sv
// UART receive frame checker: LSB-first data assembly, run-time parity check and 1/2 stop-bit check.
// Optional errored-frame counter enabled by defining RCV_ERR_COUNT_EN; otherwise ErrCount reads 0.
module rcv_frame_checker #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic                 FrameStart,
    input  logic                 BitValid,
    input  logic                 RxD,
    input  logic [1:0]           ParityMode,
    input  logic                 ClearErr,
    output logic [DATA_BITS-1:0] RxData,
    output logic                 DataValid,
    output logic                 RxParityErr,
    output logic                 RxFrameErr,
    output logic                 Busy,
    output logic [ERR_CNT_W-1:0] ErrCount
);

    localparam int               CNT_W     = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = (STOP_BITS == 2);

    typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

    state_t               state, state_nxt;
    logic [DATA_BITS-1:0] shreg;
    logic [CNT_W-1:0]     bitcnt;
    logic                 stopcnt;
    logic                 par_run;
    logic                 par_en;
    logic                 par_odd;
    logic                 par_fail;
    logic                 frm_fail;
    logic                 done;
    logic                 frm_err_now;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // FrameStart overrides everything, including a coincident BitValid.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        if (FrameStart) begin
            state_nxt = DATA;
        end else if (BitValid) begin
            case (state)
                DATA:    if (bitcnt == LAST_BIT) state_nxt = par_en ? PAR : STOP;
                PAR:     state_nxt = STOP;
                STOP: begin
                    if (stopcnt == LAST_STOP) begin
                        state_nxt = IDLE;
                        done      = 1'b1;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    // The final stop bit is still on RxD at the completion edge, so fold it in directly.
    assign frm_err_now = frm_fail | ~RxD;
    assign Busy        = (state != IDLE);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            RxData      <= '0;
            DataValid   <= 1'b0;
            RxParityErr <= 1'b0;
            RxFrameErr  <= 1'b0;
            shreg       <= '0;
            bitcnt      <= '0;
            stopcnt     <= 1'b0;
            par_run     <= 1'b0;
            par_en      <= 1'b0;
            par_odd     <= 1'b0;
            par_fail    <= 1'b0;
            frm_fail    <= 1'b0;
        end else begin
            DataValid   <= done;
            if (done) RxData <= shreg;
            RxParityErr <= (RxParityErr & ~ClearErr) | (done & par_fail);
            RxFrameErr  <= (RxFrameErr  & ~ClearErr) | (done & frm_err_now);
            if (FrameStart) begin
                bitcnt   <= '0;
                stopcnt  <= 1'b0;
                par_run  <= 1'b0;
                par_fail <= 1'b0;
                frm_fail <= 1'b0;
                par_en   <= (ParityMode == 2'b01) || (ParityMode == 2'b10);
                par_odd  <= (ParityMode == 2'b10);
            end else if (BitValid) begin
                case (state)
                    DATA: begin
                        shreg   <= {RxD, shreg[DATA_BITS-1:1]};
                        par_run <= par_run ^ RxD;
                        bitcnt  <= bitcnt + CNT_W'(1);
                    end
                    PAR: begin
                        if (RxD != (par_run ^ par_odd)) par_fail <= 1'b1;
                    end
                    STOP: begin
                        if (!RxD) frm_fail <= 1'b1;
                        stopcnt <= ~stopcnt;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef RCV_ERR_COUNT_EN
    logic frame_bad;
    assign frame_bad = done & (par_fail | frm_err_now);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)
            ErrCount <= '0;
        else if (ClearErr)
            ErrCount <= frame_bad ? ERR_CNT_W'(1) : '0;
        else if (frame_bad && (ErrCount != '1))
            ErrCount <= ErrCount + ERR_CNT_W'(1);
    end
`else
    assign ErrCount = '0;
`endif

endmodule

// File: tb/tb_rcv_frame_checker.sv
// Bench for rcv_frame_checker: a 1-stop/8-bit-count instance and a 2-stop/2-bit-count instance share stimulus.
// Every frame carries two stop strobes; the 1-stop instance sees the second one while idle and ignores it.
module tb_rcv_frame_checker;
    logic       Clock = 1'b0, Reset_n = 1'b0, FrameStart = 1'b0, BitValid = 1'b0, RxD = 1'b1, ClearErr = 1'b0;
    logic [1:0] ParityMode = 2'b00;

    logic [7:0] rxdata_a, rxdata_b, cnt_a;
    logic [1:0] cnt_b;
    logic       dv_a, pe_a, fe_a, busy_a, dv_b, pe_b, fe_b, busy_b;

    rcv_frame_checker #(.DATA_BITS(8), .STOP_BITS(1), .ERR_CNT_W(8)) u_a (
        .Clock(Clock), .Reset_n(Reset_n), .FrameStart(FrameStart), .BitValid(BitValid), .RxD(RxD),
        .ParityMode(ParityMode), .ClearErr(ClearErr), .RxData(rxdata_a), .DataValid(dv_a),
        .RxParityErr(pe_a), .RxFrameErr(fe_a), .Busy(busy_a), .ErrCount(cnt_a));

    rcv_frame_checker #(.DATA_BITS(8), .STOP_BITS(2), .ERR_CNT_W(2)) u_b (
        .Clock(Clock), .Reset_n(Reset_n), .FrameStart(FrameStart), .BitValid(BitValid), .RxD(RxD),
        .ParityMode(ParityMode), .ClearErr(ClearErr), .RxData(rxdata_b), .DataValid(dv_b),
        .RxParityErr(pe_b), .RxFrameErr(fe_b), .Busy(busy_b), .ErrCount(cnt_b));

    always #5 Clock = ~Clock;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic [7:0] cnt;
    } exp_t;

    exp_t       qa[$], qb[$];
    int         vectors = 0, miscompares = 0;
    logic       mpa = 1'b0, mfa = 1'b0, mpb = 1'b0, mfb = 1'b0;
    logic [7:0] mca = 8'd0, mcb = 8'd0;
    logic       dv_a1, dv_a2, dv_b2;

    function automatic logic [7:0] cexp(input logic [7:0] c);
`ifdef RCV_ERR_COUNT_EN
        return c;
`else
        return 8'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic strobe(input logic b);
        BitValid = 1'b1;
        RxD      = b;
        tick();
        BitValid = 1'b0;
    endtask

    task automatic model_reset();
        mpa = 1'b0; mfa = 1'b0; mca = 8'd0;
        mpb = 1'b0; mfb = 1'b0; mcb = 8'd0;
    endtask

    task automatic model_clear();
        model_reset();
    endtask

    // Predicts both instances' completion results, pushes them, then drives the frame.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] mode, input logic pbit,
                              input logic s1, input logic s2, input int gap,
                              input bit clr_last, input bit toggle, input bit fs_bv);
        exp_t e;
        logic pf, ffa, ffb, par_on;
        par_on = (mode == 2'b01) || (mode == 2'b10);
        pf  = (mode == 2'b01) ? (pbit != ^d) : (mode == 2'b10) ? (pbit != ~^d) : 1'b0;
        ffa = !s1;
        ffb = !s1 || !s2;
        mpa = mpa | pf;
        mfa = mfa | ffa;
        if ((pf || ffa) && mca != 8'hFF) mca = mca + 8'd1;
        e.d = d; e.pe = mpa; e.fe = mfa; e.cnt = mca;
        qa.push_back(e);
        if (clr_last) begin
            mpa = 1'b0; mfa = 1'b0; mca = 8'd0;
            mpb = pf; mfb = ffb; mcb = (pf || ffb) ? 8'd1 : 8'd0;
        end else begin
            mpb = mpb | pf;
            mfb = mfb | ffb;
            if ((pf || ffb) && mcb != 8'd3) mcb = mcb + 8'd1;
        end
        e.d = d; e.pe = mpb; e.fe = mfb; e.cnt = mcb;
        qb.push_back(e);

        FrameStart = 1'b1; ParityMode = mode; BitValid = fs_bv; RxD = ~d[0];
        tick();
        FrameStart = 1'b0; BitValid = 1'b0;
        if (toggle) ParityMode = (mode == 2'b00) ? 2'b01 : (mode ^ 2'b11);
        for (int i = 0; i < 8; i++) begin
            strobe(d[i]);
            idle(gap);
        end
        if (par_on) begin
            strobe(pbit);
            idle(gap);
        end
        strobe(s1);
        dv_a1 = dv_a;
        idle(gap);
        ClearErr = clr_last;
        strobe(s2);
        ClearErr = 1'b0;
        dv_a2 = dv_a;
        dv_b2 = dv_b;
        ParityMode = mode;
    endtask

    task automatic partial(input int n);
        FrameStart = 1'b1; ParityMode = 2'b01;
        tick();
        FrameStart = 1'b0;
        for (int i = 0; i < n; i++) strobe(1'b1);
    endtask

    task automatic pulse_clear();
        ClearErr = 1'b1;
        tick();
        ClearErr = 1'b0;
        model_clear();
    endtask

    // Scoreboard: every DataValid pops one prediction per instance.
    always @(negedge Clock) begin
        exp_t e;
        if (Reset_n && dv_a) begin
            if (qa.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL dv_a_spurious: DataValid=1 with no frame outstanding");
            end else begin
                e = qa.pop_front();
                vectors += 4;
                if (rxdata_a !== e.d) begin miscompares++; $display("FAIL a_rxdata: got %h want %h", rxdata_a, e.d); end
                if (pe_a !== e.pe) begin miscompares++; $display("FAIL a_parerr: got %b want %b", pe_a, e.pe); end
                if (fe_a !== e.fe) begin miscompares++; $display("FAIL a_frmerr: got %b want %b", fe_a, e.fe); end
                if (cnt_a !== cexp(e.cnt)) begin miscompares++; $display("FAIL a_errcnt: got %0d want %0d", cnt_a, cexp(e.cnt)); end
            end
        end
        if (Reset_n && dv_b) begin
            if (qb.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL dv_b_spurious: DataValid=1 with no frame outstanding");
            end else begin
                e = qb.pop_front();
                vectors += 4;
                if (rxdata_b !== e.d) begin miscompares++; $display("FAIL b_rxdata: got %h want %h", rxdata_b, e.d); end
                if (pe_b !== e.pe) begin miscompares++; $display("FAIL b_parerr: got %b want %b", pe_b, e.pe); end
                if (fe_b !== e.fe) begin miscompares++; $display("FAIL b_frmerr: got %b want %b", fe_b, e.fe); end
                if ({6'd0, cnt_b} !== cexp(e.cnt)) begin miscompares++; $display("FAIL b_errcnt: got %0d want %0d", cnt_b, cexp(e.cnt)); end
            end
        end
    end

    task automatic test_reset();
        idle(3);
        Reset_n = 1'b1;
        tick();
        vectors++;
        if ({rxdata_a, dv_a, pe_a, fe_a, busy_a, cnt_a} !== 20'd0) begin
            miscompares++; $display("FAIL por_a: got %h want 0", {rxdata_a, dv_a, pe_a, fe_a, busy_a, cnt_a});
        end
        vectors++;
        if ({rxdata_b, dv_b, pe_b, fe_b, busy_b, cnt_b} !== 14'd0) begin
            miscompares++; $display("FAIL por_b: got %h want 0", {rxdata_b, dv_b, pe_b, fe_b, busy_b, cnt_b});
        end
        // Leave RxData and sticky flags non-zero, then reset in the middle of the next frame.
        send_frame(8'h96, 2'b10, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        idle(2);
        partial(3);
        vectors++;
        if (busy_a !== 1'b1) begin miscompares++; $display("FAIL busy_mid: got %b want 1", busy_a); end
        #2 Reset_n = 1'b0;
        #1;
        vectors++;
        if ({rxdata_a, dv_a, pe_a, fe_a, busy_a, cnt_a, rxdata_b, dv_b, pe_b, fe_b, busy_b, cnt_b} !== 34'd0) begin
            miscompares++; $display("FAIL reset_mid: got %h want 0",
                {rxdata_a, dv_a, pe_a, fe_a, busy_a, cnt_a, rxdata_b, dv_b, pe_b, fe_b, busy_b, cnt_b});
        end
        model_reset();
        tick();
        Reset_n = 1'b1;
        tick();
        vectors++;
        if ({busy_a, busy_b, dv_a, dv_b} !== 4'd0) begin miscompares++; $display("FAIL busy_after_reset: got %b want 0000", {busy_a, busy_b, dv_a, dv_b}); end
        send_frame(8'hA5, 2'b01, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        idle(2);
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 2'b01, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        vectors += 3;
        if (dv_a1 !== 1'b1) begin miscompares++; $display("FAIL dv_a_timing: got %b want 1", dv_a1); end
        if (dv_a2 !== 1'b0) begin miscompares++; $display("FAIL dv_a_width: got %b want 0", dv_a2); end
        if (dv_b2 !== 1'b1) begin miscompares++; $display("FAIL dv_b_timing: got %b want 1", dv_b2); end
        idle(2);
        vectors++;
        if ({rxdata_a, pe_a, fe_a} !== {8'hA5, 2'b00}) begin miscompares++; $display("FAIL basic_hold: got %h want %h", {rxdata_a, pe_a, fe_a}, {8'hA5, 2'b00}); end
    endtask

    task automatic test_parity_odd();
        send_frame(8'h03, 2'b10, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        idle(2);
        vectors += 2;
        if ({pe_a, fe_a} !== 2'b10) begin miscompares++; $display("FAIL odd_flags: got %b want 10", {pe_a, fe_a}); end
        if (cnt_a !== cexp(8'd1)) begin miscompares++; $display("FAIL odd_cnt: got %0d want %0d", cnt_a, cexp(8'd1)); end
        pulse_clear();
        vectors += 2;
        if ({pe_a, pe_b, fe_a, fe_b} !== 4'd0) begin miscompares++; $display("FAIL clear_flags: got %b want 0000", {pe_a, pe_b, fe_a, fe_b}); end
        if (cnt_a !== 8'd0) begin miscompares++; $display("FAIL clear_cnt: got %0d want 0", cnt_a); end
    endtask

    task automatic test_stop2();
        send_frame(8'h7E, 2'b00, 1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0);
        idle(2);
        vectors += 3;
        if (fe_b !== 1'b1) begin miscompares++; $display("FAIL stop2_b_frmerr: got %b want 1", fe_b); end
        if (fe_a !== 1'b0) begin miscompares++; $display("FAIL stop2_a_frmerr: got %b want 0", fe_a); end
        if (rxdata_b !== 8'h7E) begin miscompares++; $display("FAIL stop2_b_data: got %h want 7e", rxdata_b); end
    endtask

    task automatic test_abort();
        pulse_clear();
        partial(4);
        idle(1);
        send_frame(8'h3C, 2'b01, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0);
        idle(2);
        vectors++;
        if ({rxdata_a, rxdata_b, pe_a, fe_a, pe_b, fe_b} !== {8'h3C, 8'h3C, 4'd0}) begin
            miscompares++; $display("FAIL abort_result: got %h want %h", {rxdata_a, rxdata_b, pe_a, fe_a, pe_b, fe_b}, {8'h3C, 8'h3C, 4'd0});
        end
    endtask

    task automatic test_err_count();
        logic [7:0] want;
        pulse_clear();
        for (int i = 0; i < 4; i++) begin
            send_frame(8'h01, 2'b01, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0);
            idle(1);
            want = cexp((i < 3) ? 8'(i + 1) : 8'd3);
            vectors++;
            if ({6'd0, cnt_b} !== want) begin miscompares++; $display("FAIL sat_cnt_%0d: got %0d want %0d", i, cnt_b, want); end
        end
        send_frame(8'h01, 2'b01, 1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0);
        idle(1);
        vectors += 3;
        if (pe_b !== 1'b1) begin miscompares++; $display("FAIL clr_set_flag: got %b want 1", pe_b); end
        if ({6'd0, cnt_b} !== cexp(8'd1)) begin miscompares++; $display("FAIL clr_set_cnt: got %0d want %0d", cnt_b, cexp(8'd1)); end
        if ({pe_a, cnt_a} !== 9'd0) begin miscompares++; $display("FAIL a_cleared_after: got %h want 0", {pe_a, cnt_a}); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            send_frame(8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), 0,
                       1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        idle(3);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity_odd();
        test_stop2();
        test_abort();
        test_err_count();
        test_back_to_back();
        idle(3);
        vectors++;
        if (qa.size() != 0 || qb.size() != 0) begin
            miscompares++; $display("FAIL missing_dv: got %0d/%0d frames outstanding want 0/0", qa.size(), qb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
